conv_stream_sat: RTL and testbench
==================================

// Module: conv_stream_sat
// PURPOSE
// - Parametrised 1-D streaming convolution engine with runtime-loadable filter.
// - Per frame: accepts LENX samples on the x stream and LENF coefficients on the f stream.
// - Emits LENX-LENF+1 outputs on the y stream: y[i] = sum_j x[i+j]*f[j].
// - Saturating arithmetic; ReLU is selectable.
// - Sits between the sample source and the downstream consumer in the conv datapath.
// - Successor of the fixed-ROM, always-ReLU convolver.
// PARAMETERS
// - WIDTH   20  signed data width of x, f, y
// - LENX    20  samples per frame, >= LENF
// - LENF    13  filter taps, >= 1
// - RELU    1   1: clamp negative outputs to 0; 0: pass signed result
// - ADDRX   $clog2(LENX)  x address width (derived)
// - ADDRF   $clog2(LENF)  f address width (derived)
// PORTS
// - clk           in   1      clock
// - reset         in   1      synchronous, active-high reset
// - s_data_in_x   in   WIDTH  signed sample
// - s_valid_x     in   1      sample valid
// - s_ready_x     out  1      sample ready
// - s_data_in_f   in   WIDTH  signed coefficient
// - s_valid_f     in   1      coefficient valid
// - s_ready_f     out  1      coefficient ready
// - m_data_out_y  out  WIDTH  signed result
// - m_valid_y     out  1      result valid
// - m_ready_y     in   1      result ready
// BEHAVIOUR
// - Reset: state=LOAD.
//   - s_ready_x = s_ready_f = m_valid_y = 0 during reset; m_data_out_y = 0.
//   - All counters and the accumulator are cleared.
//   - Memory contents are don't-care.
// - Handshake: a transfer occurs when valid & ready are both high on a rising edge.
//   - Valid is never gated by ready.
//   - m_data_out_y is stable while m_valid_y=1 and m_ready_y=0.
// - FSM LOAD:
//   - s_ready_x=1 while wcnt_x<LENX; s_ready_f=1 while wcnt_f<LENF.
//   - x and f load independently and concurrently; word k is written to address k.
//   - Once both counts are full (x==LENX, f==LENF), go to COMPUTE the next cycle.
//   - Both readies are 0 from the cycle the respective count fills.
// - FSM COMPUTE, for output index i (0..LENX-LENF):
//   - Issue reads x[i+j], f[j] for j=0..LENF-1, one per cycle.
//   - Pipeline: sync read (1) -> product register (1) -> accumulate (1).
//   - Go to OUT exactly LENF+3 cycles after COMPUTE entry for that i.
// - FSM OUT:
//   - m_valid_y=1 and m_data_out_y = final accumulator (after ReLU if RELU=1).
//   - On handshake: if i==LENX-LENF, go to LOAD with counters cleared; else i++, clear accumulator, go to COMPUTE.
// - Arithmetic:
//   - Full 2*WIDTH product, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//   - Sum computed at WIDTH+1 bits, saturated to the same range every tap.
//   - ReLU is applied only at the output, never per tap.
// - Boundaries:
//   - LENF==LENX: exactly 1 output per frame.
//   - s_valid_x asserted outside LOAD: ignored (ready=0); no write.
//   - No new frame is accepted until the last output handshakes; there is no overlap in this generation.
//   - Reset mid-COMPUTE or mid-OUT: m_valid_y drops to 0 the cycle after reset is sampled; the partial frame is discarded.
//   - m_ready_y high with m_valid_y low: no effect.
//   - The f memory is written only in LOAD, so a read and a write never hit the same cycle.
// STRUCTURE
// - Shared package conv_pkg:
//   - typedef enum {LOAD, COMPUTE, OUT} conv_state_t;
//   - function sat(in, WIDTH) for product and sum clamping.
// - Sub-module conv_mac_sat: product register, saturating accumulator, clear/enable, RELU output stage.
// - Reuse the existing single-port sync `memory` for both the x and f buffers.
//   - The top selects write address in LOAD and read address otherwise.
// TESTING (WIDTH=8, LENX=6, LENF=3, RELU=1 unless noted)
// - Basic: x=1..6, f=1,1,1 -> y=6,9,12,15, then s_ready_x=1 again.
// - Saturation: x=all 100, f=all 2 -> product clamps to 127, sum clamps; y=127 x4.
// - ReLU: x=1..6, f=-1,-1,-1 -> y=0 x4; with RELU=0 -> y=-6,-9,-12,-15.
// - Backpressure/stall:
//   - m_ready_y low 5 cycles on each output -> m_data_out_y held, no value lost.
//   - Random gaps on s_valid_x/s_valid_f -> same results as the Basic case.
// - Reset mid-frame:
//   - Assert reset during COMPUTE of i=1 -> m_valid_y=0 next cycle.
//   - A fresh frame then yields the Basic results.
// - Edge: LENX=LENF=3, x=2,3,4, f=1,1,1 -> single y=9, return to LOAD.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution datapath.
// Holds the control state encoding and the signed clamp used for products and sums.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUT
    } conv_state_t;

    localparam int SAT_W = 64;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] val,
                                                    input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

endpackage

// File: rtl/conv_stream_sat_if.sv
// Stream bundle for the convolver: x samples in, f coefficients in, y results out.
// The slave view belongs to the convolver; the master view belongs to its neighbours.
interface conv_stream_sat_if #(
    parameter int WIDTH = 20
);
    logic signed [WIDTH-1:0] s_data_in_x;
    logic                    s_valid_x;
    logic                    s_ready_x;
    logic signed [WIDTH-1:0] s_data_in_f;
    logic                    s_valid_f;
    logic                    s_ready_f;
    logic signed [WIDTH-1:0] m_data_out_y;
    logic                    m_valid_y;
    logic                    m_ready_y;

    modport slave (
        input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
        output s_ready_x, s_ready_f, m_data_out_y, m_valid_y
    );

    modport master (
        output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
        input  s_ready_x, s_ready_f, m_data_out_y, m_valid_y
    );
endinterface

// File: rtl/conv_mac_sat.sv
// Saturating multiply-accumulate: registered clamped product, clamped running sum,
// and an optional ReLU applied only to the value presented at the output.
module conv_mac_sat
    import conv_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter bit RELU  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    in_vld,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] f,
    output logic signed [WIDTH-1:0] y
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = WIDTH + 1;

    logic signed [WIDTH-1:0] prod_q, prod_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic                    prod_vld_q, prod_vld_d;
    logic signed [PW-1:0]    prod_full;
    logic signed [SW-1:0]    sum;

    always_comb begin
        prod_full  = PW'(x) * PW'(f);
        prod_d     = WIDTH'(sat(SAT_W'(prod_full), WIDTH));
        prod_vld_d = in_vld && !clr;
        sum        = SW'(acc_q) + SW'(prod_q);
        acc_d      = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = WIDTH'(sat(SAT_W'(sum), WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    // Negative sums are only clamped here, so intermediate taps keep their sign.
    assign y = (RELU && acc_q[WIDTH-1]) ? '0 : acc_q;
endmodule

// File: rtl/memory.sv
// Single-port synchronous RAM: one address shared by write and read,
// read data registered and available the cycle after the address is presented.
module memory #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 20,
    parameter int ADDR  = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR-1:0]  addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;

    always_comb begin
        rd_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        rd_q <= rd_d;
    end

    assign rdata = rd_q;
endmodule

// File: rtl/conv_stream_sat.sv
// 1-D streaming convolver: buffers one frame of x and f, then emits
// LENX-LENF+1 saturated dot products, one per handshake on the y stream.
module conv_stream_sat
    import conv_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int LENX  = 20,
    parameter int LENF  = 13,
    parameter bit RELU  = 1'b1,
    parameter int ADDRX = (LENX > 1) ? $clog2(LENX) : 1,
    parameter int ADDRF = (LENF > 1) ? $clog2(LENF) : 1
) (
    input logic             clk,
    input logic             reset,
    conv_stream_sat_if.slave bus
);
    localparam int XCW = ADDRX + 1;
    localparam int FCW = ADDRF + 1;
    localparam int CCW = $clog2(LENF + 3) + 1;
    localparam logic [XCW-1:0] LENX_C  = XCW'(LENX);
    localparam logic [FCW-1:0] LENF_C  = FCW'(LENF);
    localparam logic [XCW-1:0] LAST_I  = XCW'(LENX - LENF);
    localparam logic [CCW-1:0] TAPS    = CCW'(LENF);
    localparam logic [CCW-1:0] CYC_END = CCW'(LENF + 2);

    conv_state_t      state_q, state_d;
    logic [XCW-1:0]   wcnt_x_q, wcnt_x_d;
    logic [FCW-1:0]   wcnt_f_q, wcnt_f_d;
    logic [XCW-1:0]   idx_q, idx_d;
    logic [CCW-1:0]   cyc_q, cyc_d;
    logic             rd_vld_q, rd_vld_d;

    logic             ready_x, ready_f, we_x, we_f, loaded, rd_en, acc_clr;
    logic [ADDRX-1:0] addr_x;
    logic [ADDRF-1:0] addr_f;
    logic [WIDTH-1:0] rd_x, rd_f;
    logic signed [WIDTH-1:0] mac_y;

    // Readies are held low while reset is asserted, not only after it is sampled.
    always_comb begin
        ready_x = !reset && (state_q == LOAD) && (wcnt_x_q < LENX_C);
        ready_f = !reset && (state_q == LOAD) && (wcnt_f_q < LENF_C);
        we_x    = bus.s_valid_x && ready_x;
        we_f    = bus.s_valid_f && ready_f;
        loaded  = (wcnt_x_q == LENX_C) && (wcnt_f_q == LENF_C);
        rd_en   = (state_q == COMPUTE) && (cyc_q < TAPS);
        addr_x  = (state_q == LOAD) ? wcnt_x_q[ADDRX-1:0] : ADDRX'(idx_q + XCW'(cyc_q));
        addr_f  = (state_q == LOAD) ? wcnt_f_q[ADDRF-1:0] : ADDRF'(cyc_q);
    end

    // Each output takes LENF reads plus three pipeline stages before OUT.
    always_comb begin
        state_d  = state_q;
        wcnt_x_d = wcnt_x_q + XCW'(we_x);
        wcnt_f_d = wcnt_f_q + FCW'(we_f);
        idx_d    = idx_q;
        cyc_d    = cyc_q;
        rd_vld_d = rd_en;
        acc_clr  = 1'b0;
        case (state_q)
            LOAD: begin
                if (loaded) begin
                    state_d = COMPUTE;
                    idx_d   = '0;
                    cyc_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            COMPUTE: begin
                if (cyc_q == CYC_END) state_d = OUT;
                else cyc_d = cyc_q + CCW'(1);
            end
            OUT: begin
                if (bus.m_ready_y) begin
                    if (idx_q == LAST_I) begin
                        state_d  = LOAD;
                        wcnt_x_d = '0;
                        wcnt_f_d = '0;
                    end else begin
                        state_d = COMPUTE;
                        idx_d   = idx_q + XCW'(1);
                        cyc_d   = '0;
                        acc_clr = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wcnt_x_q <= '0;
            wcnt_f_q <= '0;
            idx_q    <= '0;
            cyc_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_x_q <= wcnt_x_d;
            wcnt_f_q <= wcnt_f_d;
            idx_q    <= idx_d;
            cyc_q    <= cyc_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    memory #(.WIDTH(WIDTH), .DEPTH(LENX), .ADDR(ADDRX)) u_mem_x (
        .clk   (clk),
        .we    (we_x),
        .addr  (addr_x),
        .wdata (bus.s_data_in_x),
        .rdata (rd_x)
    );

    memory #(.WIDTH(WIDTH), .DEPTH(LENF), .ADDR(ADDRF)) u_mem_f (
        .clk   (clk),
        .we    (we_f),
        .addr  (addr_f),
        .wdata (bus.s_data_in_f),
        .rdata (rd_f)
    );

    conv_mac_sat #(.WIDTH(WIDTH), .RELU(RELU)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .in_vld (rd_vld_q),
        .x      (rd_x),
        .f      (rd_f),
        .y      (mac_y)
    );

    assign bus.s_ready_x    = ready_x;
    assign bus.s_ready_f    = ready_f;
    assign bus.m_valid_y    = (state_q == OUT);
    assign bus.m_data_out_y = (state_q == OUT) ? mac_y : '0;
endmodule

// File: tb/tb_conv_stream_sat.sv
// Directed bench for conv_stream_sat: a ReLU instance, a signed-output twin driven
// in lockstep from the same stimulus, and a LENX==LENF instance.
module tb_conv_stream_sat;
    localparam int W  = 8;
    localparam int NX = 6;
    localparam int NF = 3;
    localparam int NY = NX - NF + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic signed [W-1:0] xs    [NX];
    logic signed [W-1:0] fs    [NF];
    logic signed [W-1:0] exp_a [NY];
    logic signed [W-1:0] exp_b [NY];

    always #5 clk = ~clk;

    conv_stream_sat_if #(.WIDTH(W)) bus_a ();
    conv_stream_sat_if #(.WIDTH(W)) bus_b ();
    conv_stream_sat_if #(.WIDTH(W)) bus_e ();

    conv_stream_sat #(.WIDTH(W), .LENX(NX), .LENF(NF), .RELU(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    conv_stream_sat #(.WIDTH(W), .LENX(NX), .LENF(NF), .RELU(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));
    conv_stream_sat #(.WIDTH(W), .LENX(3), .LENF(3), .RELU(1'b1)) dut_e (
        .clk(clk), .reset(reset), .bus(bus_e.slave));

    // The signed twin sees exactly the same inputs as the ReLU instance.
    assign bus_b.s_data_in_x = bus_a.s_data_in_x;
    assign bus_b.s_valid_x   = bus_a.s_valid_x;
    assign bus_b.s_data_in_f = bus_a.s_data_in_f;
    assign bus_b.s_valid_f   = bus_a.s_valid_f;
    assign bus_b.m_ready_y   = bus_a.m_ready_y;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Loads xs/fs into the main pair; entered and left on a falling edge.
    task automatic applyStimulus(input bit gaps);
        int ix = 0;
        int jf = 0;
        int guard = 0;
        bit fx, ff;
        while ((ix < NX || jf < NF) && guard < 300) begin
            bus_a.s_valid_x   = (ix < NX) && (!gaps || $urandom_range(0, 1) == 1);
            bus_a.s_data_in_x = xs[(ix < NX) ? ix : 0];
            bus_a.s_valid_f   = (jf < NF) && (!gaps || $urandom_range(0, 1) == 1);
            bus_a.s_data_in_f = fs[(jf < NF) ? jf : 0];
            #1;
            fx = bus_a.s_valid_x && bus_a.s_ready_x;
            ff = bus_a.s_valid_f && bus_a.s_ready_f;
            @(negedge clk);
            if (fx) ix++;
            if (ff) jf++;
            guard++;
        end
        bus_a.s_valid_x = 1'b0;
        bus_a.s_valid_f = 1'b0;
        checkOutput("load_done", 32'(ix == NX && jf == NF), 1);
    endtask

    // mode 0: ready pulsed per output, 1: ready held high, 2: ready low 5 cycles first
    task automatic collectOutputs(input int mode, input bit check_b);
        if (mode == 1) bus_a.m_ready_y = 1'b1;
        for (int k = 0; k < NY; k++) begin
            int guard = 0;
            while (bus_a.m_valid_y !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            checkOutput($sformatf("valid_y%0d", k), 32'(bus_a.m_valid_y), 1);
            checkOutput($sformatf("y%0d", k), bus_a.m_data_out_y, exp_a[k]);
            if (check_b) checkOutput($sformatf("y_signed%0d", k), bus_b.m_data_out_y, exp_b[k]);
            if (mode == 2) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("hold_valid%0d", k), 32'(bus_a.m_valid_y), 1);
                    checkOutput($sformatf("hold_y%0d", k), bus_a.m_data_out_y, exp_a[k]);
                end
            end
            bus_a.m_ready_y = 1'b1;
            @(negedge clk);
            if (mode != 1) bus_a.m_ready_y = 1'b0;
        end
        bus_a.m_ready_y = 1'b0;
        checkOutput("frame_valid_low", 32'(bus_a.m_valid_y), 0);
        checkOutput("ready_x_back", 32'(bus_a.s_ready_x), 1);
    endtask

    task automatic setBasic();
        for (int k = 0; k < NX; k++) xs[k] = W'(k + 1);
        for (int k = 0; k < NF; k++) fs[k] = 8'sd1;
        exp_a = '{8'sd6, 8'sd9, 8'sd12, 8'sd15};
        exp_b = exp_a;
    endtask

    task automatic waitValid(input string tag);
        int guard = 0;
        while (bus_a.m_valid_y !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, 32'(bus_a.m_valid_y), 1);
    endtask

    initial begin
        bus_a.s_data_in_x = '0; bus_a.s_valid_x = 1'b0;
        bus_a.s_data_in_f = '0; bus_a.s_valid_f = 1'b0;
        bus_a.m_ready_y   = 1'b0;
        bus_e.s_data_in_x = '0; bus_e.s_valid_x = 1'b0;
        bus_e.s_data_in_f = '0; bus_e.s_valid_f = 1'b0;
        bus_e.m_ready_y   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_ready_x", 32'(bus_a.s_ready_x), 0);
        checkOutput("rst_ready_f", 32'(bus_a.s_ready_f), 0);
        checkOutput("rst_valid_y", 32'(bus_a.m_valid_y), 0);
        checkOutput("rst_data_y", bus_a.m_data_out_y, 0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ready_x", 32'(bus_a.s_ready_x), 1);
        checkOutput("post_rst_ready_f", 32'(bus_a.s_ready_f), 1);
        @(negedge clk);

        $display("[TB] basic frame, ready held high");
        setBasic();
        applyStimulus(1'b0);
        collectOutputs(1, 1'b1);

        $display("[TB] saturation");
        for (int k = 0; k < NX; k++) xs[k] = 8'sd100;
        for (int k = 0; k < NF; k++) fs[k] = 8'sd2;
        exp_a = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        exp_b = exp_a;
        applyStimulus(1'b0);
        collectOutputs(0, 1'b1);

        $display("[TB] relu versus signed output");
        for (int k = 0; k < NX; k++) xs[k] = W'(k + 1);
        for (int k = 0; k < NF; k++) fs[k] = -8'sd1;
        exp_a = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};
        exp_b = '{-8'sd6, -8'sd9, -8'sd12, -8'sd15};
        applyStimulus(1'b0);
        collectOutputs(0, 1'b1);

        $display("[TB] backpressure with stray x valid");
        setBasic();
        applyStimulus(1'b0);
        bus_a.s_valid_x   = 1'b1;
        bus_a.s_data_in_x = -8'sd50;
        #1;
        checkOutput("stray_ready_x", 32'(bus_a.s_ready_x), 0);
        @(negedge clk);
        collectOutputs(2, 1'b1);
        bus_a.s_valid_x = 1'b0;

        $display("[TB] random input gaps");
        setBasic();
        applyStimulus(1'b1);
        collectOutputs(0, 1'b0);

        $display("[TB] reset during compute of second output");
        applyStimulus(1'b0);
        waitValid("pre_rst_valid0");
        checkOutput("pre_rst_y0", bus_a.m_data_out_y, 6);
        bus_a.m_ready_y = 1'b1;
        @(negedge clk);
        bus_a.m_ready_y = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_compute_valid", 32'(bus_a.m_valid_y), 0);
        checkOutput("rst_compute_ready_x", 32'(bus_a.s_ready_x), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset while an output is pending");
        applyStimulus(1'b0);
        waitValid("pre_rst_out_valid");
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus_a.m_valid_y), 0);
        checkOutput("rst_out_data", bus_a.m_data_out_y, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] fresh frame after reset");
        applyStimulus(1'b0);
        collectOutputs(0, 1'b1);

        $display("[TB] LENX equals LENF");
        bus_e.s_valid_x = 1'b1;
        bus_e.s_valid_f = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_e.s_data_in_x = W'(k + 2);
            bus_e.s_data_in_f = 8'sd1;
            #1;
            checkOutput($sformatf("e_ready_x%0d", k), 32'(bus_e.s_ready_x), 1);
            @(negedge clk);
        end
        bus_e.s_valid_x = 1'b0;
        bus_e.s_valid_f = 1'b0;
        checkOutput("e_full_ready_f", 32'(bus_e.s_ready_f), 0);
        begin
            int guard = 0;
            while (bus_e.m_valid_y !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        checkOutput("e_valid", 32'(bus_e.m_valid_y), 1);
        checkOutput("e_y", bus_e.m_data_out_y, 9);
        bus_e.m_ready_y = 1'b1;
        @(negedge clk);
        bus_e.m_ready_y = 1'b0;
        checkOutput("e_valid_low", 32'(bus_e.m_valid_y), 0);
        checkOutput("e_ready_x_back", 32'(bus_e.s_ready_x), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
